fdiv_pipe: RTL and testbench
============================

Name: fdiv_pipe

Overview:
- Pipelined single-precision divider. Computes d = x * (1/y).
- y goes out combinationally to the existing reciprocal unit (finv, instantiated by the parent) on inv_s; its result returns on inv_d in the same cycle.
- This block is the direct downstream consumer of finv: it captures the reciprocal, multiplies, normalizes, rounds and handles special cases.
- Three-stage valid/ready pipeline sitting between the issue logic and the FPU writeback.

Parameters:
- ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- in_valid  in  1  operands x, y valid
- in_ready  out  1  block can accept this cycle
- x  in  32  dividend, IEEE-754 single
- y  in  32  divisor, IEEE-754 single
- inv_s  out  32  to finv input; equals y, purely combinational
- inv_d  in  32  from finv output; combinational function of inv_s
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- d  out  32  quotient
- overflow  out  1  result saturated to infinity (valid with d)
- underflow  out  1  result flushed to zero (valid with d)
- div_by_zero  out  1  y exponent field was 0 (valid with d)

Behaviour:
- Reset (rstn=0 at posedge): all stage valid bits clear; out_valid=0, d=0, overflow=0, underflow=0, div_by_zero=0. Data registers not otherwise required to reset.
- Stall model: single global enable en = !out_valid | out_ready. in_ready = en. A transfer occurs when in_valid & in_ready. All three stages advance only when en=1.
- Latency: exactly 3 enabled cycles from accept to out_valid. Throughput 1/cycle with no backpressure. d and flags are held stable while out_valid=1 and out_ready=0.
- Stage A (accept edge), registers:
  - x, inv_d, y-zero flag (ey==0), x-zero flag (ex==0), x-inf flag (ex==255), y-inf flag (ey==255).
  - sign = sx ^ sr.
- Stage B:
  - mp = {1,mx} * {1,mr}, 48 bits.
  - e = ex + er - 127, as a 10-bit signed value.
- Stage C:
  - If mp[47]=1: mantissa = mp[46:24], guard = mp[23], sticky = |mp[22:0], e += 1.
  - Else: mantissa = mp[45:23], guard = mp[22], sticky = |mp[21:0].
  - RNE: increment when guard & (sticky | lsb). A mantissa carry-out sets mantissa=0 and e += 1.
  - ROUND_EN=0 never increments.
- Range checks (on final e):
  - e >= 255: d = {sign, 8'hFF, 0}, overflow=1.
  - e <= 0: d = {sign, 0, 0}, underflow=1. Denormals are never produced.
- Special-case priority (first match wins):
  1. y zero & x zero: d = 32'h7FC00000, div_by_zero=1.
  2. y zero: d = {sign, 8'hFF, 0}, div_by_zero=1.
  3. x zero or y inf: d = {sign, 0, 0}, no flags.
  4. x inf: d = {sign, 8'hFF, 0}, no flags.
  5. Otherwise: normal path.
- Flags are mutually exclusive per result and all 0 on normal in-range results.
- Denormal inputs are treated as zero, by exponent field only.
- Reset mid-operation discards all in-flight results; the first cycle after release has in_ready=1.
- If out_ready=1 and in_valid=1 in the same cycle, the pipeline shifts and accepts at once; no bubble.

Decomposition:
- Shared package fpu_pkg:
  - field-slice constants (SIGN_BIT, EXP_MSB/LSB, MAN_MSB/LSB);
  - EXP_BIAS=127, EXP_MAX=255;
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000.
- One sub-module: fround_norm, the combinational normalize + RNE + range-check used in stage C. It is reusable by fmul.
- finv stays external; it is not instantiated here.

Test Plan:
- Normal divide: x=0x40C00000 (6.0), y=0x40000000, bench inv_d=0x3F000000, out_ready=1 -> after 3 cycles d=0x40400000, all flags 0.
- Divide by zero: x=0x3F800000, y=0x00000000 -> d=0x7F800000, div_by_zero=1. Then x=0, y=0 -> d=0x7FC00000, div_by_zero=1.
- Overflow/underflow:
  - x=0x7F000000, y=0x00800000, inv_d=0x7E800000 -> d=0x7F800000, overflow=1.
  - x=0x00800000, y=0x40000000, inv_d=0x3F000000 -> d=0x00000000, underflow=1.
- Rounding tie: x=0x3F800001, inv_d=0x3F400000.
  - ROUND_EN=1 -> d=0x3F400002.
  - ROUND_EN=0 -> d=0x3F400001.
- Backpressure: 4 back-to-back inputs with out_ready=0 from cycle 2 -> in_ready drops; d is held stable. Releasing out_ready yields all 4 results in order, with no loss or duplication.
- Reset: rstn=0 for 1 cycle while 2 ops are in flight -> out_valid=0 next cycle; no stale result ever appears; a new op completes in 3 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared single-precision field layout, constants and special-case flags for
// the FPU datapath blocks (fdiv_pipe, fmul, ...).
package fpu_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Operand classification travelling down the pipe alongside the data.
  typedef struct packed {
    logic x_zero;
    logic y_zero;
    logic x_inf;
    logic y_inf;
  } spec_t;

  function automatic logic [7:0] exp_field(input logic [31:0] f);
    return f[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/fround_norm.sv
// Combinational normalize, round-to-nearest-even and exponent range check for
// a 48-bit mantissa product (1.x * 1.x). Shared by the divider and multiplier.
module fround_norm
  import fpu_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic [47:0]        i_mp,
  input  logic signed [9:0]  i_exp,
  input  logic               i_sign,
  output logic [31:0]        o_res,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);

  logic [22:0]       w_man;
  logic              w_guard;
  logic              w_sticky;
  logic signed [9:0] w_exp_n;
  logic              w_inc;
  logic [23:0]       w_man_rnd;
  logic signed [9:0] w_exp_r;

  // NOTE: every output of an always_comb gets a default before any branch, so no latch can be inferred.
  always_comb begin
    w_man    = i_mp[45:23];
    w_guard  = i_mp[22];
    w_sticky = |i_mp[21:0];
    w_exp_n  = i_exp;
    if (i_mp[47]) begin
      w_man    = i_mp[46:24];
      w_guard  = i_mp[23];
      w_sticky = |i_mp[22:0];
      w_exp_n  = i_exp + 10'sd1;
    end
  end

  assign w_inc     = ROUND_EN & w_guard & (w_sticky | w_man[0]);
  // A carry out of the rounded mantissa leaves the fraction bits at zero.
  assign w_man_rnd = {1'b0, w_man} + 24'(w_inc);
  assign w_exp_r   = w_exp_n + (w_man_rnd[23] ? 10'sd1 : 10'sd0);

  always_comb begin
    o_res       = {i_sign, w_exp_r[7:0], w_man_rnd[22:0]};
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (w_exp_r >= EXP_TOP) begin
      o_res      = {i_sign, 8'hFF, 23'd0};
      o_overflow = 1'b1;
    end else if (w_exp_r <= 10'sd0) begin
      o_res       = {i_sign, 31'd0};
      o_underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fdiv_pipe.sv
// Three-stage pipelined single-precision divider d = x * (1/y); the reciprocal
// comes from an external finv driven combinationally from inv_s.
module fdiv_pipe
  import fpu_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] inv_s,
  input  logic [31:0] inv_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  logic w_en;
  logic w_accept;

  // Stage A: captured operands
  logic        r_a_valid;
  logic        r_a_sign;
  logic [31:0] r_a_x;
  logic [31:0] r_a_r;
  spec_t       r_a_spec;

  // Stage B: raw product and unnormalized exponent
  logic              r_b_valid;
  logic              r_b_sign;
  logic [47:0]       r_b_mp;
  logic signed [9:0] r_b_exp;
  spec_t             r_b_spec;

  // Stage C: registered outputs
  logic        r_out_valid;
  logic [31:0] r_d;
  logic        r_ovf;
  logic        r_unf;
  logic        r_dbz;

  logic [47:0]       w_mp;
  logic signed [9:0] w_exp;
  logic [31:0]       w_rn_res;
  logic              w_rn_ovf;
  logic              w_rn_unf;
  logic [31:0]       w_d;
  logic              w_ovf;
  logic              w_unf;
  logic              w_dbz;

  // One global enable: the whole pipe freezes while a result waits at the output.
  assign w_en     = !r_out_valid | out_ready;
  assign w_accept = in_valid & w_en;
  assign in_ready = w_en;
  assign inv_s    = y;

  assign w_mp  = 48'({1'b1, r_a_x[MAN_MSB:MAN_LSB]}) * 48'({1'b1, r_a_r[MAN_MSB:MAN_LSB]});
  assign w_exp = $signed({2'b00, exp_field(r_a_x)}) + $signed({2'b00, exp_field(r_a_r)})
               - $signed(10'(EXP_BIAS));

  fround_norm #(.ROUND_EN(ROUND_EN)) u_round (
    .i_mp        (r_b_mp),
    .i_exp       (r_b_exp),
    .i_sign      (r_b_sign),
    .o_res       (w_rn_res),
    .o_overflow  (w_rn_ovf),
    .o_underflow (w_rn_unf)
  );

  always_comb begin
    w_d   = w_rn_res;
    w_ovf = w_rn_ovf;
    w_unf = w_rn_unf;
    w_dbz = 1'b0;
    if (r_b_spec.y_zero && r_b_spec.x_zero) begin
      w_d   = QNAN;
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_dbz = 1'b1;
    end else if (r_b_spec.y_zero) begin
      w_d   = {r_b_sign, POS_INF[30:0]};
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_dbz = 1'b1;
    end else if (r_b_spec.x_zero || r_b_spec.y_inf) begin
      w_d   = {r_b_sign, 31'd0};
      w_ovf = 1'b0;
      w_unf = 1'b0;
    end else if (r_b_spec.x_inf) begin
      w_d   = {r_b_sign, POS_INF[30:0]};
      w_ovf = 1'b0;
      w_unf = 1'b0;
    end
  end

  // Control and visible outputs: these carry the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_a_valid   <= 1'b0;
      r_b_valid   <= 1'b0;
      r_out_valid <= 1'b0;
      r_d         <= 32'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else if (w_en) begin
      r_a_valid   <= w_accept;
      r_b_valid   <= r_a_valid;
      r_out_valid <= r_b_valid;
      if (r_b_valid) begin
        r_d   <= w_d;
        r_ovf <= w_ovf;
        r_unf <= w_unf;
        r_dbz <= w_dbz;
      end
    end
  end

  // NOTE: datapath registers have no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_a_x           <= x;
      r_a_r           <= inv_d;
      r_a_sign        <= x[SIGN_BIT] ^ inv_d[SIGN_BIT];
      r_a_spec.x_zero <= exp_field(x) == 8'd0;
      r_a_spec.y_zero <= exp_field(y) == 8'd0;
      r_a_spec.x_inf  <= exp_field(x) == 8'(EXP_MAX);
      r_a_spec.y_inf  <= exp_field(y) == 8'(EXP_MAX);
      r_b_mp          <= w_mp;
      r_b_exp         <= w_exp;
      r_b_sign        <= r_a_sign;
      r_b_spec        <= r_a_spec;
    end
  end

  assign out_valid   = r_out_valid;
  assign d           = r_d;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_fdiv_pipe.sv
// Directed bench for fdiv_pipe: a round-to-nearest and a truncating instance
// share stimulus; expected results are hand-computed constants.
module tb_fdiv_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic [31:0] inv_d = 32'd0;

  logic        in_ready, out_valid, overflow, underflow, div_by_zero;
  logic [31:0] inv_s, d;
  logic        in_ready_t, out_valid_t, overflow_t, underflow_t, div_by_zero_t;
  logic [31:0] inv_s_t, d_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fdiv_pipe #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .inv_s(inv_s), .inv_d(inv_d),
    .out_valid(out_valid), .out_ready(out_ready), .d(d),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  fdiv_pipe #(.ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
    .x(x), .y(y), .inv_s(inv_s_t), .inv_d(inv_d),
    .out_valid(out_valid_t), .out_ready(out_ready), .d(d_t),
    .overflow(overflow_t), .underflow(underflow_t), .div_by_zero(div_by_zero_t)
  );

  // One isolated operation; flags expected as {overflow, underflow, div_by_zero}.
  task automatic run_op(input string name, input logic [31:0] vx, input logic [31:0] vy,
                        input logic [31:0] vinv, input logic [31:0] exp_d,
                        input logic [31:0] exp_dt, input logic [2:0] exp_f);
    int lat;
    @(posedge clk); #1;
    x = vx; y = vy; inv_d = vinv; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (inv_s !== vy) begin
      errors++; $display("FAIL %s inv_s: got %h want %h", name, inv_s, vy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL %s latency: got %0d want 3", name, lat);
    end
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL %s d: got %h want %h", name, d, exp_d);
    end
    checks++;
    if ({overflow, underflow, div_by_zero} !== exp_f) begin
      errors++; $display("FAIL %s flags: got %b want %b", name, {overflow, underflow, div_by_zero}, exp_f);
    end
    checks++;
    if (out_valid_t !== 1'b1 || d_t !== exp_dt) begin
      errors++; $display("FAIL %s trunc d: got %h (valid %b) want %h", name, d_t, out_valid_t, exp_dt);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, overflow, underflow, div_by_zero} !== 4'b0000 || d !== 32'd0) begin
      errors++;
      $display("FAIL reset state: got valid=%b d=%h flags=%b%b%b want all zero",
               out_valid, d, overflow, underflow, div_by_zero);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
    rstn = 1'b1;
  endtask

  task automatic test_normal();
    run_op("div_6_by_2",   32'h40C0_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4040_0000, 3'b000);
    run_op("div_neg6_by_2", 32'hC0C0_0000, 32'h4000_0000, 32'h3F00_0000, 32'hC040_0000, 32'hC040_0000, 3'b000);
    run_op("div_8_by_2",   32'h4100_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4080_0000, 32'h4080_0000, 3'b000);
  endtask

  task automatic test_div_by_zero();
    run_op("one_by_zero",  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b001);
    run_op("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 3'b001);
  endtask

  task automatic test_range();
    run_op("overflow",  32'h7F00_0000, 32'h0080_0000, 32'h7E80_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b100);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, 3'b010);
  endtask

  task automatic test_rounding();
    run_op("rne_tie", 32'h3F80_0001, 32'h3FAA_AAAB, 32'h3F40_0000, 32'h3F40_0002, 32'h3F40_0001, 3'b000);
  endtask

  task automatic test_special();
    run_op("x_zero", 32'h0000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, 3'b000);
    run_op("y_inf",  32'h4040_0000, 32'hFF80_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000);
    run_op("x_inf",  32'h7F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b000);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ox [4];
    logic [31:0] oexp [4];
    logic [31:0] held;
    bit have_held = 1'b0;
    bit saw_stall = 1'b0;
    bit extra = 1'b0;
    int sent = 0;
    int recv = 0;
    ox   = '{32'h40C0_0000, 32'h4000_0000, 32'h4100_0000, 32'h3F80_0000};
    oexp = '{32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F00_0000};
    held = 32'd0;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && recv < 4; c++) begin
      out_ready = !(c >= 2 && c < 8);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        x = ox[sent]; y = 32'h4000_0000; inv_d = 32'h3F00_0000;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (d !== oexp[recv]) begin
          errors++; $display("FAIL b2b result %0d: got %h want %h", recv, d, oexp[recv]);
        end
        recv++;
        have_held = 1'b0;
      end else if (out_valid && !out_ready) begin
        saw_stall = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b stall in_ready: got %b want 0", in_ready);
        end
        if (have_held) begin
          checks++;
          if (d !== held) begin
            errors++; $display("FAIL b2b held d: got %h want %h", d, held);
          end
        end else begin
          held = d;
          have_held = 1'b1;
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv !== 4 || !saw_stall) begin
      errors++; $display("FAIL b2b count: got %0d results (stall seen %b) want 4 with stall", recv, saw_stall);
    end
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++; $display("FAIL b2b duplicate: got extra out_valid want none");
    end
  endtask

  task automatic test_reset_in_flight();
    bit stale = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    x = 32'h40C0_0000; y = 32'h4000_0000; inv_d = 32'h3F00_0000;
    @(posedge clk); #1;
    x = 32'h4100_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_flight after: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++; $display("FAIL reset_flight stale: got out_valid want none");
    end
    run_op("after_reset", 32'h4000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_by_zero();
    test_range();
    test_rounding();
    test_special();
    test_back_to_back();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
